// File: rtl/vdp_cpu_port_pkg.sv
// vdp_cpu_port_pkg: shared types and defaults for the V9958 CPU port bridge.
package vdp_cpu_port_pkg;
  localparam int FILTER_LEN_DEF = 3;
  localparam int FIFO_DEPTH_DEF = 4;
  typedef enum logic [1:0] {IDLE, WREQ, RREQ, RHOLD} issue_state_e;
  typedef struct packed {
    logic [1:0] adr;
    logic [7:0] data;
  } fifo_entry_t;
endpackage

// File: rtl/vdp_cpu_port_strobe.sv
// io_strobe_filter: 2-flop synchroniser plus run-length deglitch filter with fall pulse.
module io_strobe_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk_w,
  input  logic reset_n_w,
  input  logic strobe_n,
  output logic filt,
  output logic fall
);
  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  logic [1:0] sync_q, sync_d;
  logic filt_q, filt_d, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    sync_d = {sync_q[0], strobe_n};
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) filt_d = sync_q[1];
      else cnt_d = cnt_q + CW'(1);
    end
  end
  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      prev_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      prev_q <= filt_q;
      cnt_q  <= cnt_d;
    end
  end
  assign filt = filt_q;
  assign fall = prev_q & ~filt_q;
endmodule

// File: rtl/vdp_cpu_port.sv
// vdp_cpu_port: Z80 port strobes to V9958 REQ/ACK bridge with write posting FIFO.
module vdp_cpu_port
  import vdp_cpu_port_pkg::*;
#(
  parameter int FILTER_LEN = FILTER_LEN_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                          clk_w,
  input  logic                          reset_n_w,
  input  logic                          csr_n,
  input  logic                          csw_n,
  input  logic [1:0]                    port_addr,
  input  logic [7:0]                    cd_in,
  output logic [7:0]                    cd_out,
  output logic                          wait_n,
  output logic                          vdp_req,
  output logic                          vdp_wrt,
  output logic [1:0]                    vdp_adr,
  output logic [7:0]                    vdp_dbo,
  input  logic                          vdp_ack,
  input  logic [7:0]                    vdp_dbi,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  issue_state_e state_q, state_d;
  fifo_entry_t bus_s1_q, bus_s2_q, head;
  fifo_entry_t mem_q [FIFO_DEPTH];
  fifo_entry_t mem_d [FIFO_DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [LW-1:0] level_q, level_d;
  logic overflow_q, overflow_d, read_pending_q, read_pending_d, wait_n_q, wait_n_d;
  logic req_q, req_d, wrt_q, wrt_d;
  logic [1:0] adr_q, adr_d, rd_adr_q, rd_adr_d;
  logic [7:0] dbo_q, dbo_d, cd_out_q, cd_out_d;
  logic r_filt, r_fall, w_filt, w_fall, wr_ev, rd_ev, full, push, pop, rd_done;
  io_strobe_filter #(.FILTER_LEN(FILTER_LEN)) u_rd (
    .clk_w(clk_w), .reset_n_w(reset_n_w), .strobe_n(csr_n), .filt(r_filt), .fall(r_fall));
  io_strobe_filter #(.FILTER_LEN(FILTER_LEN)) u_wr (
    .clk_w(clk_w), .reset_n_w(reset_n_w), .strobe_n(csw_n), .filt(w_filt), .fall(w_fall));
  // A fall while the other strobe is also low is a bus conflict and is dropped.
  assign wr_ev = w_fall & r_filt;
  assign rd_ev = r_fall & w_filt & ~read_pending_q;
  assign full  = level_q == LW'(FIFO_DEPTH);
  assign push  = wr_ev & ~full;
  assign head  = mem_q[rp_q];
  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (level_q != '0) ? WREQ : read_pending_q ? RREQ : IDLE;
      WREQ:    state_d = vdp_ack ? IDLE : WREQ;
      RREQ:    state_d = vdp_ack ? RHOLD : RREQ;
      default: state_d = r_filt ? IDLE : RHOLD;
    endcase
  end
  // The head entry stays counted until its ack, so an in-flight write occupies a slot.
  always_comb begin
    req_d    = req_q;
    wrt_d    = wrt_q;
    adr_d    = adr_q;
    dbo_d    = dbo_q;
    cd_out_d = cd_out_q;
    pop      = 1'b0;
    rd_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (level_q != '0) begin
          req_d = 1'b1;
          wrt_d = 1'b1;
          adr_d = head.adr;
          dbo_d = head.data;
        end else if (read_pending_q) begin
          req_d = 1'b1;
          wrt_d = 1'b0;
          adr_d = rd_adr_q;
        end
      end
      WREQ: begin
        req_d = vdp_ack ? 1'b0 : req_q;
        pop   = vdp_ack;
      end
      RREQ: begin
        req_d    = vdp_ack ? 1'b0 : req_q;
        cd_out_d = vdp_ack ? vdp_dbi : cd_out_q;
        rd_done  = vdp_ack;
      end
      default: ;
    endcase
  end
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wp_q] = bus_s2_q;
    wp_d           = push ? wp_q + AW'(1) : wp_q;
    rp_d           = pop ? rp_q + AW'(1) : rp_q;
    level_d        = level_q + LW'(push) - LW'(pop);
    overflow_d     = overflow_q | (wr_ev & full);
    read_pending_d = (read_pending_q | rd_ev) & ~rd_done;
    rd_adr_d       = rd_ev ? bus_s2_q.adr : rd_adr_q;
    wait_n_d       = ~read_pending_q | rd_done;
  end
  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      bus_s1_q       <= '0;
      bus_s2_q       <= '0;
      mem_q          <= '{default: '0};
      wp_q           <= '0;
      rp_q           <= '0;
      level_q        <= '0;
      overflow_q     <= 1'b0;
      read_pending_q <= 1'b0;
      rd_adr_q       <= '0;
      wait_n_q       <= 1'b1;
      req_q          <= 1'b0;
      wrt_q          <= 1'b0;
      adr_q          <= '0;
      dbo_q          <= '0;
      cd_out_q       <= '0;
    end else begin
      bus_s1_q       <= {port_addr, cd_in};
      bus_s2_q       <= bus_s1_q;
      mem_q          <= mem_d;
      wp_q           <= wp_d;
      rp_q           <= rp_d;
      level_q        <= level_d;
      overflow_q     <= overflow_d;
      read_pending_q <= read_pending_d;
      rd_adr_q       <= rd_adr_d;
      wait_n_q       <= wait_n_d;
      req_q          <= req_d;
      wrt_q          <= wrt_d;
      adr_q          <= adr_d;
      dbo_q          <= dbo_d;
      cd_out_q       <= cd_out_d;
    end
  end
  assign cd_out     = cd_out_q;
  assign wait_n     = wait_n_q;
  assign vdp_req    = req_q;
  assign vdp_wrt    = wrt_q;
  assign vdp_adr    = adr_q;
  assign vdp_dbo    = dbo_q;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;
endmodule

// File: tb/tb_vdp_cpu_port.sv
// tb_vdp_cpu_port: scoreboard bench; expected VDP transactions queued at stimulus, checked at ack.
module tb_vdp_cpu_port;
  logic clk_w = 1'b0, reset_n_w = 1'b0, csr_n = 1'b1, csw_n = 1'b1, vdp_ack = 1'b0;
  logic [1:0] port_addr = '0;
  logic [7:0] cd_in = '0, vdp_dbi = '0;
  logic [7:0] cd_out, vdp_dbo;
  logic wait_n, vdp_req, vdp_wrt, overflow;
  logic [1:0] vdp_adr;
  logic [2:0] fifo_level;
  int n_tests = 0, n_fail = 0, n_ack = 0, dly = 0, ack_dly = 2, a0 = 0;
  bit ack_en = 1'b1, wait_ok;
  logic [7:0] rd_data = 8'h3C;
  logic [10:0] exp_q[$];
  logic [10:0] e;

  vdp_cpu_port dut (
    .clk_w(clk_w), .reset_n_w(reset_n_w), .csr_n(csr_n), .csw_n(csw_n),
    .port_addr(port_addr), .cd_in(cd_in), .cd_out(cd_out), .wait_n(wait_n),
    .vdp_req(vdp_req), .vdp_wrt(vdp_wrt), .vdp_adr(vdp_adr), .vdp_dbo(vdp_dbo),
    .vdp_ack(vdp_ack), .vdp_dbi(vdp_dbi), .fifo_level(fifo_level), .overflow(overflow));

  always #5 clk_w = ~clk_w;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic strobe(input bit rd, input bit wr, input logic [1:0] a, input logic [7:0] d,
                        input int lo, input int hi);
    port_addr = a;
    cd_in = d;
    csr_n = ~rd;
    csw_n = ~wr;
    repeat (lo) @(negedge clk_w);
    csr_n = 1'b1;
    csw_n = 1'b1;
    repeat (hi) @(negedge clk_w);
  endtask

  task automatic wait_drain(input string tag, input int max);
    for (int i = 0; i < max && (exp_q.size() != 0 || vdp_req || fifo_level != 0); i++)
      @(negedge clk_w);
    chk(tag, exp_q.size(), 0);
  endtask

  // VDP model: acks a held request ack_dly cycles later and scores the transaction.
  initial begin
    forever begin
      @(negedge clk_w);
      vdp_ack = 1'b0;
      if (vdp_req && ack_en) begin
        if (dly >= ack_dly) begin
          vdp_ack = 1'b1;
          vdp_dbi = rd_data;
          dly = 0;
          n_ack++;
          if (exp_q.size() == 0) chk("req_without_expect", exp_q.size(), 1);
          else begin
            e = exp_q.pop_front();
            chk("vdp_txn", {vdp_wrt, vdp_adr, vdp_wrt ? vdp_dbo : 8'h00}, e);
          end
        end else dly++;
      end else dly = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk_w);
    chk("rst_cd_out", cd_out, 0);
    chk("rst_wait_n", wait_n, 1);
    chk("rst_req", vdp_req, 0);
    chk("rst_wrt", vdp_wrt, 0);
    chk("rst_adr", vdp_adr, 0);
    chk("rst_dbo", vdp_dbo, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_overflow", overflow, 0);
    reset_n_w = 1'b1;
    repeat (3) @(negedge clk_w);
    // single write, request timing counted from edge 0
    a0 = n_ack;
    port_addr = 2'd1;
    cd_in = 8'hA5;
    csw_n = 1'b0;
    exp_q.push_back({1'b1, 2'd1, 8'hA5});
    repeat (6) @(negedge clk_w);
    chk("w_req_before_edge6", vdp_req, 0);
    chk("w_level_after_push", fifo_level, 1);
    @(negedge clk_w);
    chk("w_req_edge6", vdp_req, 1);
    chk("w_wrt", vdp_wrt, 1);
    chk("w_adr", vdp_adr, 1);
    chk("w_dbo", vdp_dbo, 8'hA5);
    repeat (13) @(negedge clk_w);
    csw_n = 1'b1;
    wait_drain("w_drain", 40);
    chk("w_single_ack", n_ack - a0, 1);
    // glitch shorter than the filter
    a0 = n_ack;
    strobe(1'b0, 1'b1, 2'd2, 8'h5A, 2, 15);
    chk("glitch_level", fifo_level, 0);
    chk("glitch_req", vdp_req, 0);
    chk("glitch_acks", n_ack - a0, 0);
    // overflow with ack held off
    ack_en = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back({1'b1, i[1:0], i[7:0]});
      strobe(1'b0, 1'b1, i[1:0], i[7:0], 8, 8);
    end
    chk("ovf_level", fifo_level, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_inflight_dbo", vdp_dbo, 8'h01);
    ack_en = 1'b1;
    wait_drain("ovf_drain", 100);
    chk("ovf_level_drained", fifo_level, 0);
    chk("ovf_sticky", overflow, 1);
    // read queued behind two posted writes
    ack_en = 1'b0;
    a0 = n_ack;
    exp_q.push_back({1'b1, 2'd0, 8'h11});
    strobe(1'b0, 1'b1, 2'd0, 8'h11, 8, 8);
    exp_q.push_back({1'b1, 2'd1, 8'h22});
    strobe(1'b0, 1'b1, 2'd1, 8'h22, 8, 8);
    exp_q.push_back({1'b0, 2'd2, 8'h00});
    port_addr = 2'd2;
    csr_n = 1'b0;
    repeat (8) @(negedge clk_w);
    chk("rb_wait_low", wait_n, 0);
    ack_en = 1'b1;
    for (int i = 0; i < 60 && !wait_n; i++) @(negedge clk_w);
    chk("rb_acks_at_release", n_ack - a0, 3);
    chk("rb_wait_high", wait_n, 1);
    chk("rb_cd_out", cd_out, 8'h3C);
    rd_data = 8'h99;
    repeat (6) @(negedge clk_w);
    chk("rb_cd_held", cd_out, 8'h3C);
    csr_n = 1'b1;
    repeat (10) @(negedge clk_w);
    wait_drain("rb_drain", 40);
    rd_data = 8'h3C;
    // simultaneous strobes are ignored
    a0 = n_ack;
    wait_ok = 1'b1;
    csr_n = 1'b0;
    csw_n = 1'b0;
    repeat (12) begin
      @(negedge clk_w);
      if (!wait_n) wait_ok = 1'b0;
    end
    csr_n = 1'b1;
    csw_n = 1'b1;
    repeat (10) @(negedge clk_w);
    chk("sim_wait_n", wait_ok, 1);
    chk("sim_level", fifo_level, 0);
    chk("sim_acks", n_ack - a0, 0);
    // reset during an outstanding read
    ack_en = 1'b0;
    port_addr = 2'd3;
    csr_n = 1'b0;
    exp_q.push_back({1'b0, 2'd3, 8'h00});
    for (int i = 0; i < 20 && !vdp_req; i++) @(negedge clk_w);
    chk("rr_req_seen", vdp_req, 1);
    chk("rr_wait_low", wait_n, 0);
    #2 reset_n_w = 1'b0;
    #1;
    chk("rr_req_async", vdp_req, 0);
    chk("rr_wait_async", wait_n, 1);
    chk("rr_level_async", fifo_level, 0);
    chk("rr_ovf_async", overflow, 0);
    exp_q.delete();
    csr_n = 1'b1;
    repeat (3) @(negedge clk_w);
    reset_n_w = 1'b1;
    ack_en = 1'b1;
    repeat (2) @(negedge clk_w);
    a0 = n_ack;
    exp_q.push_back({1'b1, 2'd2, 8'hC3});
    strobe(1'b0, 1'b1, 2'd2, 8'hC3, 20, 10);
    wait_drain("rr_post_drain", 40);
    chk("rr_post_acks", n_ack - a0, 1);
    chk("rr_post_ovf", overflow, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
